// File: rtl/byte_packer.sv
// Packs a valid/ready byte stream into little-endian BYTES-wide words with a
// per-lane keep mask; a pending partial word is flushed after TIMEOUT idle cycles.
module byte_packer #(
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*BYTES-1:0]   out_data,
  output logic [BYTES-1:0]     out_keep
);

  localparam int CNT_W  = $clog2(BYTES);
  localparam int IDLE_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam bit                FLUSH_EN  = (TIMEOUT != 0);

  logic [8*BYTES-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               out_valid_q, out_valid_d;
  logic [8*BYTES-1:0] out_data_q, out_data_d;
  logic [BYTES-1:0]   out_keep_q, out_keep_d;

  logic slot_free;
  logic flush;
  logic in_ready_c;
  logic accept;

  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    flush      = FLUSH_EN && (cnt_q != '0) && (idle_q == IDLE_MAX) && slot_free;
    // The completing lane needs the output slot; earlier lanes only need the accumulator.
    in_ready_c = !flush && ((cnt_q != LAST_LANE) || slot_free);
    accept     = in_valid && in_ready_c;
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      idle_d = '0;
      if (cnt_q == LAST_LANE) begin
        out_valid_d                    = 1'b1;
        out_data_d                     = acc_q;
        out_data_d[8*(BYTES-1) +: 8]   = in_data;
        out_keep_d                     = '1;
        acc_d                          = '0;
        cnt_d                          = '0;
      end else begin
        acc_d[8*cnt_q +: 8] = in_data;
        cnt_d               = cnt_q + 1'b1;
      end
    end else if (flush) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q;
      out_keep_d  = ~({BYTES{1'b1}} << cnt_q);
      acc_d       = '0;
      cnt_d       = '0;
      idle_d      = '0;
    end else if (cnt_q == '0) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;

endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer: table-driven streaming/backpressure vectors
// plus hand-written reset, timeout-flush and TIMEOUT=0 sequences.
module tb_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [7:0]  z_in_data;
  logic [31:0] z_out_data;
  logic [3:0]  z_out_keep;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  byte_packer #(.BYTES(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep)
  );

  byte_packer #(.BYTES(4), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_data(z_out_data), .out_keep(z_out_keep)
  );

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic ordy,
                     input logic e_ir, input logic e_ov,
                     input logic [31:0] e_data, input logic [3:0] e_keep);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov;
    v.e_data = e_data; v.e_keep = e_keep;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic zstep(input logic iv, input logic [7:0] d);
    @(negedge clk);
    z_in_valid  = iv;
    z_in_data   = d;
    z_out_ready = 1'b1;
    #1;
  endtask

  initial begin
    int premature;
    int z_seen;

    rst = 1'b0;
    in_valid = 0; in_data = 0; out_ready = 0;
    z_in_valid = 0; z_in_data = 0; z_out_ready = 0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_keep", out_keep, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_nt_out_valid", z_out_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Streaming: 12 bytes at full rate, words at cycles 4, 8, 12.
    for (int i = 0; i < 12; i++) begin
      case (i)
        4:       add(1, 8'h10 + 8'(i), 1, 1, 1, 32'h13121110, 4'hF);
        8:       add(1, 8'h10 + 8'(i), 1, 1, 1, 32'h17161514, 4'hF);
        default: add(1, 8'h10 + 8'(i), 1, 1, 0, 32'h0, 4'h0);
      endcase
    end
    add(0, 8'h00, 1, 1, 1, 32'h1B1A1918, 4'hF);
    add(0, 8'h00, 1, 1, 0, 32'h0, 4'h0);
    // Backpressure: first word held, lanes 0..2 still accepted, lane 3 stalls.
    add(1, 8'hA0, 0, 1, 0, 32'h0, 4'h0);
    add(1, 8'hA1, 0, 1, 0, 32'h0, 4'h0);
    add(1, 8'hA2, 0, 1, 0, 32'h0, 4'h0);
    add(1, 8'hA3, 0, 1, 0, 32'h0, 4'h0);
    add(1, 8'hA4, 0, 1, 1, 32'hA3A2A1A0, 4'hF);
    add(1, 8'hA5, 0, 1, 1, 32'hA3A2A1A0, 4'hF);
    add(1, 8'hA6, 0, 1, 1, 32'hA3A2A1A0, 4'hF);
    add(1, 8'hA7, 0, 0, 1, 32'hA3A2A1A0, 4'hF);
    add(1, 8'hA7, 1, 1, 1, 32'hA3A2A1A0, 4'hF);
    add(0, 8'h00, 1, 1, 1, 32'hA7A6A5A4, 4'hF);
    add(0, 8'h00, 1, 1, 0, 32'h0, 4'h0);

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_data);
        chk($sformatf("vec%0d_out_keep", i), out_keep, vecs[i].e_keep);
      end
    end

    // Timeout flush: two bytes, then 15 idle cycles, then the flush cycle.
    step(1, 8'h55, 1);
    step(1, 8'h66, 1);
    premature = 0;
    for (int k = 0; k < 15; k++) begin
      step(0, 8'h00, 1);
      if (!in_ready || out_valid) premature++;
    end
    chk("timeout_no_early_flush", premature, 0);
    step(0, 8'h00, 1);
    chk("timeout_flush_in_ready", in_ready, 0);
    chk("timeout_flush_out_valid", out_valid, 0);
    step(0, 8'h00, 1);
    chk("timeout_out_valid", out_valid, 1);
    chk("timeout_out_data", out_data, 32'h00006655);
    chk("timeout_out_keep", out_keep, 4'b0011);
    step(0, 8'h00, 1);
    chk("timeout_drained", out_valid, 0);

    // Flush under blocked output: full word held, one byte pending for 40 cycles.
    step(1, 8'h81, 0);
    step(1, 8'h82, 0);
    step(1, 8'h83, 0);
    step(1, 8'h84, 0);
    step(1, 8'h77, 0);
    chk("blocked_accept_77", in_ready, 1);
    for (int k = 0; k < 40; k++) step(0, 8'h00, 0);
    chk("blocked_held_valid", out_valid, 1);
    chk("blocked_held_data", out_data, 32'h84838281);
    chk("blocked_in_ready", in_ready, 1);
    step(0, 8'h00, 1);
    chk("blocked_flush_in_ready", in_ready, 0);
    chk("blocked_full_taken", out_data, 32'h84838281);
    step(0, 8'h00, 1);
    chk("blocked_flush_valid", out_valid, 1);
    chk("blocked_flush_data", out_data, 32'h00000077);
    chk("blocked_flush_keep", out_keep, 4'b0001);
    step(0, 8'h00, 1);

    // Reset mid-word with a word pending.
    step(1, 8'h91, 0);
    step(1, 8'h92, 0);
    step(1, 8'h93, 0);
    step(1, 8'h94, 0);
    step(1, 8'h95, 0);
    step(1, 8'h96, 0);
    step(0, 8'h00, 0);
    chk("pre_reset_out_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_keep", out_keep, 0);
    chk("midreset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    step(1, 8'h01, 1);
    step(1, 8'h02, 1);
    step(1, 8'h03, 1);
    step(1, 8'h04, 1);
    chk("post_reset_no_early", out_valid, 0);
    step(0, 8'h00, 1);
    chk("post_reset_valid", out_valid, 1);
    chk("post_reset_data", out_data, 32'h04030201);
    chk("post_reset_keep", out_keep, 4'b1111);
    step(0, 8'h00, 1);

    // TIMEOUT=0 instance never flushes a partial word.
    zstep(1, 8'hC0);
    zstep(1, 8'hC1);
    zstep(1, 8'hC2);
    z_seen = 0;
    for (int k = 0; k < 100; k++) begin
      zstep(0, 8'h00);
      if (z_out_valid || !z_in_ready) z_seen++;
    end
    chk("nt_no_flush", z_seen, 0);
    zstep(1, 8'hC3);
    zstep(0, 8'h00);
    chk("nt_out_valid", z_out_valid, 1);
    chk("nt_out_data", z_out_data, 32'hC3C2C1C0);
    chk("nt_out_keep", z_out_keep, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Downstream consumer of the 8-bit valid/ready byte FIFO stage.
- Packs consecutive bytes into BYTES-wide words, little-endian: first byte goes to lane 0 = bits [7:0].
- Presents each word on a registered valid/ready output with a per-lane keep mask.
- A partial word is flushed after TIMEOUT idle cycles, so the tail of a byte stream never stalls.

Parameters:
- BYTES, 4, bytes per output word (2..8).
- TIMEOUT, 15, consecutive no-accept cycles with a partial word pending before it is flushed; 0 disables flushing.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset); synchronous deassert done externally.
- in_valid  input  1  byte available from upstream FIFO.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- in_data  input  8  byte payload.
- out_valid  output  1  word held in output register.
- out_ready  input  1  downstream accepts word when out_valid && out_ready.
- out_data  output  8*BYTES  packed word; unused lanes are zero.
- out_keep  output  BYTES  lane i valid; always contiguous from lane 0.

Behaviour:
- State:
  - accumulator acc[8*BYTES-1:0].
  - lane count cnt (0..BYTES-1).
  - idle counter idle (saturating at TIMEOUT).
  - output register {out_valid, out_data, out_keep}.
- Reset (rst=0, immediate, regardless of clk):
  - acc=0, cnt=0, idle=0.
  - out_valid=0, out_data=0, out_keep=0.
  - Any partial or pending word is discarded; no output handshake occurs during reset.
- Output slot:
  - slot_free = !out_valid || out_ready.
  - The output register loads only when slot_free.
  - When out_valid=1 && out_ready=0, out_data and out_keep hold stable.
- Flush condition:
  - flush = (TIMEOUT!=0) && cnt!=0 && idle==TIMEOUT && slot_free.
- in_ready:
  - in_ready = !flush && (cnt<BYTES-1 || slot_free). Combinational; no dependence on in_valid.
- Accept, non-completing (cnt<BYTES-1):
  - Byte written to lane cnt of acc; cnt+=1; idle=0.
- Accept, completing (cnt==BYTES-1):
  - out_data = acc with lane BYTES-1 = in_data; out_keep = all ones; out_valid=1.
  - acc=0, cnt=0, idle=0.
  - Latency: the last byte accepted in cycle N produces out_valid=1 in cycle N+1.
- Flush:
  - out_data=acc, out_keep=(1<<cnt)-1, out_valid=1; acc=0, cnt=0, idle=0.
  - in_ready=0 that cycle, so no byte is lost or merged.
- Idle counting:
  - When cnt!=0 and no byte is accepted and no flush, idle increments, saturating at TIMEOUT.
  - When cnt==0, idle=0.
  - With the output blocked, idle stays saturated and the flush fires on the first slot_free cycle.
- Output drain:
  - If out_valid && out_ready and no new load, out_valid=0.
  - out_data and out_keep keep their last value; the bench must not check them while out_valid=0.
- Simultaneous drain and load in the same cycle:
  - The new word replaces the old one; back-to-back words at full rate, 1 word per BYTES cycles.
- Throughput:
  - With out_ready held high, in_ready stays high continuously (except flush cycles), i.e. 1 byte/cycle.
- Backpressure:
  - With out_valid=1 && out_ready=0, bytes for lanes 0..BYTES-2 are still accepted.
  - in_ready drops only when cnt==BYTES-1.
- Ordering: bytes are never dropped, duplicated or reordered.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 mid-word (cnt=2) with out_valid=1.
  - Response: out_valid=0, out_keep=0, in_ready=1 immediately.
  - After release, bytes 0x01..0x04 produce a single word 0x04030201 with keep=4'b1111.
- Streaming:
  - Stimulus: out_ready=1, 12 bytes 0x10..0x1B on consecutive cycles.
  - Response: words 0x13121110, 0x17161514, 0x1B1A1918 on cycles 4, 8, 12 after the first accept; in_ready never low.
- Backpressure:
  - Stimulus: out_ready=0, feed 8 bytes 0xA0..0xA7.
  - Response: first word 0xA3A2A1A0 held stable; bytes 0xA4..0xA6 accepted; in_ready=0 at 0xA7.
  - On out_ready=1: 0xA7 accepted that cycle, second word 0xA7A6A5A4 follows next cycle.
- Timeout flush:
  - Stimulus: TIMEOUT=15, out_ready=1, send 0x55, 0x66, then in_valid=0.
  - Response: after exactly 15 idle cycles, the flush cycle shows in_ready=0; the next cycle presents out_data=0x00006655, keep=4'b0011.
- Flush under blocked output:
  - Stimulus: hold a full word unaccepted, send 1 byte 0x77, wait 40 cycles, then out_ready=1.
  - Response: full word is taken first; the next cycle presents 0x00000077 with keep=4'b0001.
- TIMEOUT=0:
  - Stimulus: send 3 bytes, idle 100 cycles.
  - Response: no output; a 4th byte completes the word normally.
